// File: rtl/calc_pkg.sv
// Shared definitions for the calculator result digit transmitter: ASCII codes,
// FSM state encoding and the decimal place-value helper.
package calc_pkg;

   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam logic [7:0] ASCII_LF   = 8'h0A;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CONV = 3'd1,
      EMIT = 3'd2,
      CR   = 3'd3,
      LF   = 3'd4,
      FIN  = 3'd5
   } state_t;

   // 10^place; the loop bound covers every place that fits in 32 bits.
   function automatic logic [31:0] pow10(input int place);
      logic [31:0] r;
      r = 32'd1;
      for (int i = 0; i < 9; i++) begin
         if (i < place) r = r * 32'd10;
      end
      return r;
   endfunction

endpackage

// File: rtl/dec_place_sub.sv
// One decimal place of repeated subtraction: flags whether the remainder still
// holds another multiple of the place value and provides the reduced remainder.
module dec_place_sub
   import calc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int PW    = 9
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [PW-1:0]    place_val,
   output logic             ge,
   output logic [WIDTH-1:0] diff
);

   logic [PW-1:0] rem_ext;

   assign rem_ext = {{(PW-WIDTH){1'b0}}, rem};
   assign ge      = (rem_ext >= place_val);
   // Only consumed when ge is set, so the place value fits in WIDTH bits here.
   assign diff    = rem - place_val[WIDTH-1:0];

endmodule

// File: rtl/calc_result_digit_tx.sv
// Binary-to-ASCII decimal transmitter: emits the digits of value MSB first over
// a valid/ready byte stream. Define CALC_DIGIT_TX_CRLF_EN to append CR LF.
module calc_result_digit_tx
   import calc_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] value,
   output logic             busy,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic             done
);

   // Place constants: 10^k < 16^k, so 4 bits per digit always suffices.
   localparam int PW  = (WIDTH + 1 > 4 * DIGITS) ? WIDTH + 1 : 4 * DIGITS;
   localparam int PLW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [PLW-1:0]   place_q, place_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             seen_q, seen_d;
   logic [7:0]       data_q, data_d;

   logic [PW-1:0]    place_val;
   logic             ge;
   logic [WIDTH-1:0] diff;

   assign place_val = PW'(pow10(int'(place_q)));

   dec_place_sub #(
      .WIDTH (WIDTH),
      .PW    (PW)
   ) u_dec_place_sub (
      .rem       (rem_q),
      .place_val (place_val),
      .ge        (ge),
      .diff      (diff)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         place_q <= '0;
         cnt_q   <= '0;
         seen_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         place_q <= place_d;
         cnt_q   <= cnt_d;
         seen_q  <= seen_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      place_d = place_q;
      cnt_d   = cnt_q;
      seen_d  = seen_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               rem_d   = value;
               place_d = PLW'(DIGITS - 1);
               cnt_d   = 4'd0;
               seen_d  = 1'b0;
               state_d = CONV;
            end
         end
         CONV: begin
            if (ge) begin
               rem_d = diff;
               cnt_d = cnt_q + 4'd1;
            end else if (cnt_q != 4'd0 || seen_q || place_q == '0) begin
               data_d  = ASCII_ZERO + {4'd0, cnt_q};
               seen_d  = 1'b1;
               state_d = EMIT;
            end else begin
               // Leading zero: skip the place without emitting anything.
               place_d = place_q - PLW'(1);
               cnt_d   = 4'd0;
            end
         end
         EMIT: begin
            if (tx_ready) begin
               if (place_q == '0) begin
`ifdef CALC_DIGIT_TX_CRLF_EN
                  data_d  = ASCII_CR;
                  state_d = CR;
`else
                  state_d = FIN;
`endif
               end else begin
                  place_d = place_q - PLW'(1);
                  cnt_d   = 4'd0;
                  state_d = CONV;
               end
            end
         end
`ifdef CALC_DIGIT_TX_CRLF_EN
         CR: begin
            if (tx_ready) begin
               data_d  = ASCII_LF;
               state_d = LF;
            end
         end
         LF: begin
            if (tx_ready) state_d = FIN;
         end
`endif
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Byte holding states drive tx_valid; tx_data is only reloaded on exit.
   assign tx_valid = (state_q == EMIT) || (state_q == CR) || (state_q == LF);
   assign busy     = (state_q != IDLE) && (state_q != FIN);
   assign done     = (state_q == FIN);
   assign tx_data  = data_q;

endmodule

// File: tb/tb_calc_result_digit_tx.sv
// Scoreboard bench for calc_result_digit_tx: a decimal reference model queues
// expected bytes and CONV-cycle gaps; a negedge monitor checks the stream.
module tb_calc_result_digit_tx;

   localparam int WIDTH  = 8;
   localparam int DIGITS = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] value;
   logic             busy;
   logic [7:0]       tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic             done;

   typedef struct {
      logic [7:0] data;
      int         gap;
      bit         last;
   } exp_t;

   exp_t       q[$];
   int         checks = 0;
   int         errors = 0;
   int         gap_cnt = 0;
   bit         held = 1'b0;
   logic [7:0] held_data = 8'h00;
   bit         done_due = 1'b0;
   bit         mon_en = 1'b0;
   int         n_acc = 0;
   int         ready_mode = 0;
   int         stall = 0;

   calc_result_digit_tx #(
      .WIDTH  (WIDTH),
      .DIGITS (DIGITS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .value    (value),
      .busy     (busy),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: decimal digits by division; each digit d costs d+1
   // conversion cycles, and every suppressed leading place one more cycle.
   function automatic void push_model(input int v);
      int   dg[$];
      int   t;
      exp_t e;
      t = v;
      do begin
         dg.push_front(t % 10);
         t = t / 10;
      end while (t > 0);
      for (int i = 0; i < dg.size(); i++) begin
         e.data = 8'h30 + 8'(dg[i]);
         e.gap  = ((i == 0) ? (DIGITS - dg.size()) : 0) + dg[i] + 1;
`ifdef CALC_DIGIT_TX_CRLF_EN
         e.last = 1'b0;
`else
         e.last = (i == dg.size() - 1);
`endif
         q.push_back(e);
      end
`ifdef CALC_DIGIT_TX_CRLF_EN
      e.data = 8'h0D; e.gap = 0; e.last = 1'b0; q.push_back(e);
      e.data = 8'h0A; e.gap = 0; e.last = 1'b1; q.push_back(e);
`endif
   endfunction

   // Monitor
   always @(negedge clk) begin
      if (mon_en) begin
         if (done_due) begin
            chk("done_pulse", {31'd0, done}, 32'd1);
            chk("busy_at_done", {31'd0, busy}, 32'd0);
            done_due = 1'b0;
         end else if (done) begin
            chk("unexpected_done", {31'd0, done}, 32'd0);
         end
         if (tx_valid) begin
            if (held) begin
               chk("data_stable", {24'd0, tx_data}, {24'd0, held_data});
            end else if (q.size() == 0) begin
               chk("unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
            end else begin
               chk("conv_gap", gap_cnt, q[0].gap);
            end
            if (tx_ready) begin
               if (q.size() > 0) begin
                  exp_t e;
                  e = q.pop_front();
                  chk("tx_data", {24'd0, tx_data}, {24'd0, e.data});
                  n_acc++;
                  if (e.last) done_due = 1'b1;
               end
               held    = 1'b0;
               gap_cnt = 0;
            end else begin
               held      = 1'b1;
               held_data = tx_data;
            end
         end else begin
            gap_cnt++;
         end
      end
   end

   // Downstream ready generator
   always @(posedge clk) begin
      if (tx_valid && tx_ready) stall = 0;
      #1;
      case (ready_mode)
         0: tx_ready = 1'b1;
         1: tx_ready = 1'($urandom_range(0, 1));
         2: begin
            if (tx_valid) begin
               stall++;
               tx_ready = (stall > 5);
            end else begin
               tx_ready = 1'($urandom_range(0, 1));
            end
         end
         default: tx_ready = 1'b0;
      endcase
   end

   initial begin
      repeat (50000) @(posedge clk);
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || q.size() != 0 || done_due || done) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) chk("idle_timeout", n, 0);
      @(negedge clk);
   endtask

   task automatic run(input int v);
      wait_idle();
      push_model(v);
      value = WIDTH'(v);
      start = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      gap_cnt = 0;
   endtask

   initial begin
      int base;
      int n;
      bit saw_done;
      rst      = 1'b1;
      start    = 1'b0;
      value    = '0;
      tx_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
      rst    = 1'b0;
      mon_en = 1'b1;

      ready_mode = 0;
      run(0);
      run(255);
      run(7);
      run(100);

      ready_mode = 2;
      run(42);

      // A second start during a conversion must be ignored.
      ready_mode = 0;
      run(123);
      @(negedge clk);
      chk("busy_during_conv", {31'd0, busy}, 32'd1);
      value = WIDTH'(9);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;

      // Reset while the second digit of 200 is being held.
      ready_mode = 2;
      run(200);
      base = n_acc;
      n = 0;
      while (!((n_acc - base) == 1 && tx_valid && tx_data == 8'h30) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) chk("second_digit_timeout", n, 0);
      mon_en = 1'b0;
      rst    = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_tx_valid", {31'd0, tx_valid}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      rst      = 1'b0;
      q.delete();
      held     = 1'b0;
      done_due = 1'b0;
      saw_done = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      chk("abort_no_done", {31'd0, saw_done}, 32'd0);
      mon_en     = 1'b1;
      ready_mode = 0;
      run(5);

`ifdef CALC_DIGIT_TX_CRLF_EN
      run(12);
`endif

      ready_mode = 1;
      for (int i = 0; i < 25; i++) run(int'($urandom_range(0, 255)));
      run(255);
      run(0);
      ready_mode = 0;
      for (int i = 0; i < 10; i++) run(int'($urandom_range(0, 255)));

      wait_idle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
